demux_deser: RTL
================

Name: demux_deser

Overview:
- Serial-to-parallel demultiplexing receiver. It is the receive end of the time-multiplexed serial link driven by the team's 2:1 mux-based serializer.
- Collects framed serial bits, one per qualified cycle, into a WIDTH-bit word.
- Presents each word on a valid/ready output port with a single holding register.
- Sits between the pad-side serial input and the SoC-side word consumer.

Parameters:
- WIDTH, 8, bits per frame/output word (>=2).
- MSB_FIRST, 1, 1: first received bit lands in DOUT[WIDTH-1]; 0: first bit lands in DOUT[0].

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous reset, active-high.
- SIN  input  1  serial data bit.
- SIN_VALID  input  1  SIN qualified this cycle.
- SOF  input  1  start-of-frame; only meaningful with SIN_VALID=1; marks the first bit of a frame.
- DOUT  output  WIDTH  assembled word.
- DOUT_VALID  output  1  DOUT holds an unconsumed word.
- DOUT_READY  input  1  consumer accepts DOUT this cycle.
- BUSY  output  1  frame in progress (state SHIFT).
- OVERRUN  output  1  sticky: a completed word was dropped.
- CLR_OVR  input  1  synchronous clear of OVERRUN.

Behaviour:
- Reset (async, RST=1): state=IDLE; bit counter=0; shift register=0; DOUT=0; DOUT_VALID=0; BUSY=0; OVERRUN=0. Takes effect immediately, mid-frame included; the partial frame is discarded.
- Bit counter width is clog2(WIDTH+1). The shift register is WIDTH bits.
- MSB_FIRST=1: shift left, new bit into bit 0. MSB_FIRST=0: shift right, new bit into bit WIDTH-1.
- IDLE:
  - SIN_VALID & SOF: shift in SIN, count=1, go to SHIFT (BUSY=1 next cycle).
  - SIN_VALID without SOF: bit ignored, stay in IDLE.
- SHIFT:
  - SIN_VALID & SOF: restart. Discard the partial word, shift SIN in as bit 1, count=1. No error flag.
  - SIN_VALID, no SOF: shift in, count+1.
  - SIN_VALID=0: hold all state (gaps of any length are allowed).
  - When the shifted-in bit makes count==WIDTH: the word is complete; go to IDLE and reset count to 0.
- Word completion, evaluated on the completing edge:
  - Holding register empty, or DOUT_VALID&DOUT_READY on the same edge: DOUT<=word, DOUT_VALID=1. Latency is one cycle: last bit sampled at edge k, DOUT_VALID high after edge k.
  - DOUT_VALID=1 and DOUT_READY=0: the new word is dropped, DOUT is unchanged, OVERRUN<=1.
- Handshake: DOUT_VALID&DOUT_READY with no completing word clears DOUT_VALID. DOUT holds its last value. DOUT is stable while DOUT_VALID=1 and DOUT_READY=0.
- Back-to-back frames: an SOF on the cycle right after completion (in IDLE) is accepted. There are no dead cycles.
- OVERRUN:
  - Set has priority over CLR_OVR on the same edge.
  - Otherwise CLR_OVR=1 clears it.
  - Remains set until cleared or reset.
- Registered outputs only. No combinational path from inputs to outputs.

Optional Feature:
- Macro: DEMUX_DESER_INVERT_EN.
- Defined: SIN is inverted before entering the shift register. This matches the inverting output polarity of the mux-cell serializer, so DOUT equals the transmitter's original word. SOF and SIN_VALID are not inverted.
- Undefined: SIN is shifted in true polarity.

Test Plan (WIDTH=8, MSB_FIRST=1, macro undefined unless stated):
- Reset, then SOF with bits 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles, DOUT_READY=1 -> DOUT=8'hA5; DOUT_VALID high exactly 1 cycle, starting one cycle after the 8th bit; BUSY high during bits 2-8.
- Same frame with SIN_VALID deasserted for 3 cycles after bit 4 -> DOUT=8'hA5, completion delayed by 3 cycles. Same frame with MSB_FIRST=0 -> DOUT=8'hA5 bit-reversed = 8'hA5 (palindrome); then send 8'h01 MSB-first pattern -> DOUT=8'h80.
- Frame 8'h3C completes with DOUT_READY=0, then frame 8'hC3 completes -> DOUT stays 8'h3C, OVERRUN=1; CLR_OVR pulse -> OVERRUN=0; DOUT_READY pulse -> DOUT_VALID=0.
- Frame 8'h11 held; DOUT_READY=1 on the same edge that frame 8'h22 completes -> DOUT=8'h22, DOUT_VALID stays 1, OVERRUN=0.
- 4 bits of a frame, then SOF with 8'hF0 -> DOUT=8'hF0 only. RST pulse after 5 bits of another frame -> all outputs 0; a following full frame 8'h5A -> DOUT=8'h5A.
- With DEMUX_DESER_INVERT_EN defined, input bits 0,1,0,1,1,0,1,0 -> DOUT=8'hA5.

Source files
------------

// File: rtl/demux_deser_if.sv
// Serial-in / word-out bundle for demux_deser. The receiver connects through the
// slave modport; the serial source and word consumer drive through master.
interface demux_deser_if #(
   parameter int WIDTH = 8
);
   logic             sin;
   logic             sin_valid;
   logic             sof;
   logic             dout_ready;
   logic             clr_ovr;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             busy;
   logic             overrun;

   modport master (
      output sin, sin_valid, sof, dout_ready, clr_ovr,
      input  dout, dout_valid, busy, overrun
   );

   modport slave (
      input  sin, sin_valid, sof, dout_ready, clr_ovr,
      output dout, dout_valid, busy, overrun
   );
endinterface

// File: rtl/demux_deser.sv
// Framed serial-to-parallel receiver with a single valid/ready holding register.
// Define DEMUX_DESER_INVERT_EN to invert SIN ahead of the shift register.
module demux_deser #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   demux_deser_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [WIDTH-1:0] shift_base, shift_word;
   logic [WIDTH-1:0] dout_reg;
   logic             dout_valid_reg;
   logic             overrun_reg;
   logic             word_done;
   logic             sin_bit;
   logic             load_word, drop_word;
   logic             busy;

`ifdef DEMUX_DESER_INVERT_EN
   assign sin_bit = ~bus.sin;
`else
   assign sin_bit = bus.sin;
`endif

   // An SOF always starts from a clean register so a restarted frame carries no stale bits.
   assign shift_base = bus.sof ? '0 : shift_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_in
               assign shift_word[gi] = sin_bit;
            end else begin : g_mv
               assign shift_word[gi] = shift_base[gi-1];
            end
         end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_in
               assign shift_word[gi] = sin_bit;
            end else begin : g_mv
               assign shift_word[gi] = shift_base[gi+1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         count_reg <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         shift_reg <= shift_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      shift_next = shift_reg;
      word_done  = 1'b0;
      if (bus.sin_valid) begin
         case (state_reg)
            IDLE: begin
               if (bus.sof) begin
                  shift_next = shift_word;
                  count_next = CW'(1);
                  state_next = SHIFT;
               end
            end
            SHIFT: begin
               shift_next = shift_word;
               if (bus.sof) begin
                  count_next = CW'(1);
               end else if (count_reg == CW'(WIDTH - 1)) begin
                  word_done  = 1'b1;
                  count_next = '0;
                  state_next = IDLE;
               end else begin
                  count_next = count_reg + CW'(1);
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_reg == SHIFT);
   end

   // A word is accepted if the holding register is empty or being drained on this edge.
   assign load_word = word_done & (~dout_valid_reg | bus.dout_ready);
   assign drop_word = word_done & dout_valid_reg & ~bus.dout_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         if (load_word) begin
            dout_reg       <= shift_next;
            dout_valid_reg <= 1'b1;
         end else if (dout_valid_reg && bus.dout_ready) begin
            dout_valid_reg <= 1'b0;
         end
         if (drop_word) begin
            overrun_reg <= 1'b1;
         end else if (bus.clr_ovr) begin
            overrun_reg <= 1'b0;
         end
      end
   end

   assign bus.dout       = dout_reg;
   assign bus.dout_valid = dout_valid_reg;
   assign bus.busy       = busy;
   assign bus.overrun    = overrun_reg;
endmodule
